branch_judge: RTL and testbench
===============================

Name: branch_judge

Overview:
- Branch-condition evaluator for the multi-cycle RISC-V CPU datapath.
- Takes a signed comparison result `imm` (typically ALU rs1−rs2 or a similar difference) and a 2-bit branch type. Outputs a combinational taken/not-taken flag.
- Also provides a registered, strobe-qualified copy of the decision for the control FSM, plus optional taken/evaluation statistics counters.

Parameters:
- WIDTH, 16, bit width of signed input `imm`.
- CNT_WIDTH, 16, width of statistics counters.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- imm  input  WIDTH  signed two's-complement value under test.
- BType  input  2  branch condition select.
- eval  input  1  capture strobe; sampled on rising clk.
- clr_stats  input  1  synchronous clear of statistics counters.
- out  output  1  combinational branch decision.
- out_q  output  1  registered decision.
- out_q_valid  output  1  high for one cycle after a captured evaluation.
- taken_cnt  output  CNT_WIDTH  number of captured evaluations with decision 1.
- eval_cnt  output  CNT_WIDTH  number of captured evaluations.

Behaviour:
- `out` is purely combinational from `imm` and `BType`. It is independent of clk and rst_n and valid within the same delta as any input change.
  - BType=0: out = (imm == 0)  (eq)
  - BType=1: out = (imm >= 0)  (ge, signed)
  - BType=2: out = (imm > 0)   (gt, signed)
  - BType=3: out = (imm != 0)  (ne)
- All comparisons are signed over the full WIDTH bits.
  - Most-negative value (0x8000 for WIDTH=16) is negative: gives 0 for types 0/1/2 and 1 for type 3.
  - X/Z on `BType` need not be handled; no default-to-1 fallthrough (case is full).
- Reset (rst_n low, asynchronous): out_q=0, out_q_valid=0, taken_cnt=0, eval_cnt=0. Takes effect immediately and holds while low.
- Release of reset is synchronous to clk. First capture occurs at the first rising edge with rst_n high.
- Each rising clk:
  - If eval=1: out_q <= out; out_q_valid <= 1.
  - If eval=0: out_q holds; out_q_valid <= 0.
  - Latency: out_q reflects inputs sampled one edge earlier.
- Back-to-back eval strobes capture every cycle; out_q_valid stays high continuously.
- Counters (only when stats enabled; see Optional Feature):
  - On a rising edge with eval=1: eval_cnt += 1, and taken_cnt += 1 if out=1.
  - Both counters saturate at all-ones; no wrap.
  - clr_stats=1 zeroes both counters on that edge and has priority over a simultaneous eval increment, which is dropped.
  - clr_stats does not affect out_q or out_q_valid.
- Reset asserted mid-operation discards any pending capture.

Optional Feature:
- Macro BRANCH_JUDGE_STATS_EN.
  - Defined: taken_cnt and eval_cnt behave as above.
  - Undefined: no counter registers are built; taken_cnt and eval_cnt are constant 0 and clr_stats is ignored. `out`, out_q and out_q_valid are identical in both builds.

Test Plan:
- imm=0, BType swept 0..3 -> out = 1,1,0,0 respectively, checked 10 ns after each change.
- imm=3, BType swept 0..3 -> out = 0,1,1,1; imm=-99, BType 0..3 -> out = 0,0,0,1.
- Boundaries: imm=1 and imm=-1, and imm=0x7FFF and 0x8000 for all BType. Check against the signed eq/ge/gt/ne rules, e.g. 0x8000 BType=1 -> 0, BType=3 -> 1.
- Registered path: imm=3, BType=2, eval pulsed one cycle -> out_q=1 and out_q_valid=1 after that edge, then out_q_valid=0 next cycle with out_q held at 1. Assert rst_n=0 between edges -> out_q=0 and out_q_valid=0 immediately.
- Stats (with BRANCH_JUDGE_STATS_EN): 5 eval strobes, of which 3 are taken -> eval_cnt=5, taken_cnt=3. Then clr_stats together with eval -> both counters 0. Run with CNT_WIDTH=4 for 20 taken strobes -> both counters saturate at 15.
- Without BRANCH_JUDGE_STATS_EN: the same stats stimulus -> counters read 0 throughout, and out/out_q behave identically to the stats-enabled build.

Source files
------------

// File: rtl/branch_judge_if.sv
// Branch judge bus: operand, branch type, capture strobe and results.
// Master drives the comparison request, slave returns the decisions.
interface branch_judge_if #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 16
);
   logic signed [WIDTH-1:0] imm;
   logic [1:0]              BType;
   logic                    eval;
   logic                    clr_stats;
   logic                    out;
   logic                    out_q;
   logic                    out_q_valid;
   logic [CNT_WIDTH-1:0]    taken_cnt;
   logic [CNT_WIDTH-1:0]    eval_cnt;

   modport master (
      output imm, BType, eval, clr_stats,
      input  out, out_q, out_q_valid,
      input  taken_cnt, eval_cnt
   );

   modport slave (
      input  imm, BType, eval, clr_stats,
      output out, out_q, out_q_valid,
      output taken_cnt, eval_cnt
   );
endinterface

// File: rtl/branch_judge.sv
// Signed branch-condition evaluator with registered decision.
// Statistics counters are built only when BRANCH_JUDGE_STATS_EN is defined.
module branch_judge #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 16
) (
   input logic            clk,
   input logic            rst_n,
   branch_judge_if.slave  bus
);
   logic neg;
   logic zero;
   logic dec;

   assign neg  = bus.imm[WIDTH-1];
   assign zero = (bus.imm == '0);

   // Decode branch type into eq/ge/gt/ne on the signed operand
   always_comb begin
      dec = 1'b0;
      unique case (1'b1)
         (bus.BType == 2'd0): dec = zero;
         (bus.BType == 2'd1): dec = !neg;
         (bus.BType == 2'd2): dec = !neg && !zero;
         (bus.BType == 2'd3): dec = !zero;
      endcase
   end

   assign bus.out = dec;

   logic q;
   logic qv;

   // Capture the decision on each eval strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q  <= 1'b0;
         qv <= 1'b0;
      end else begin
         qv <= bus.eval;
         if (bus.eval)
            q <= dec;
      end
   end

   assign bus.out_q       = q;
   assign bus.out_q_valid = qv;

`ifdef BRANCH_JUDGE_STATS_EN
   logic [CNT_WIDTH-1:0] tcnt;
   logic [CNT_WIDTH-1:0] ecnt;

   // Saturating counters; clear wins over a same-cycle eval
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt <= '0;
         ecnt <= '0;
      end else if (bus.clr_stats) begin
         tcnt <= '0;
         ecnt <= '0;
      end else if (bus.eval) begin
         if (ecnt != '1)
            ecnt <= ecnt + 1'b1;
         if (dec && tcnt != '1)
            tcnt <= tcnt + 1'b1;
      end
   end

   assign bus.taken_cnt = tcnt;
   assign bus.eval_cnt  = ecnt;
`else
   logic unused_clr;
   assign unused_clr    = bus.clr_stats;
   assign bus.taken_cnt = {CNT_WIDTH{1'b0}};
   assign bus.eval_cnt  = {CNT_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_branch_judge.sv
// Bench for branch_judge: directed vectors plus a behavioural model
// checked every negedge, on a 16-bit and a 4-bit counter instance.
module tb_branch_judge;
`ifdef BRANCH_JUDGE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   branch_judge_if #(.WIDTH(16), .CNT_WIDTH(16)) bus ();
   branch_judge_if #(.WIDTH(16), .CNT_WIDTH(4))  bus4 ();

   branch_judge #(.WIDTH(16), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   branch_judge #(.WIDTH(16), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic bit decide(input int v, input int t);
      case (t)
         0: return v == 0;
         1: return v >= 0;
         2: return v > 0;
         default: return v != 0;
      endcase
   endfunction

   function automatic int sat(input int c, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (c > mx) ? mx : c;
   endfunction

   task automatic drive(input logic [15:0] v, input logic [1:0] t,
                        input logic ev, input logic clr);
      bus.imm        = v;
      bus.BType      = t;
      bus.eval       = ev;
      bus.clr_stats  = clr;
      bus4.imm       = v;
      bus4.BType     = t;
      bus4.eval      = ev;
      bus4.clr_stats = clr;
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Model state: last captured decision, valid flag, raw counts
   bit m_q = 0;
   bit m_v = 0;
   int m_ev = 0;
   int m_tk = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q  <= 0;
         m_v  <= 0;
         m_ev <= 0;
         m_tk <= 0;
      end else begin
         m_v <= bus.eval;
         if (bus.eval)
            m_q <= decide(int'(bus.imm), int'(bus.BType));
         if (bus.clr_stats) begin
            m_ev <= 0;
            m_tk <= 0;
         end else if (bus.eval) begin
            m_ev <= m_ev + 1;
            m_tk <= m_tk + int'(decide(int'(bus.imm), int'(bus.BType)));
         end
      end
   end

   // Compare both instances against the model every cycle
   always @(negedge clk) begin
      bit d;
      d = decide(int'(bus.imm), int'(bus.BType));
      chk("out", 32'(bus.out), 32'(d));
      chk("out4", 32'(bus4.out), 32'(d));
      chk("out_q", 32'(bus.out_q), 32'(m_q));
      chk("out_q4", 32'(bus4.out_q), 32'(m_q));
      chk("valid", 32'(bus.out_q_valid), 32'(m_v));
      chk("valid4", 32'(bus4.out_q_valid), 32'(m_v));
      chk("eval_cnt", 32'(bus.eval_cnt),
          STATS ? 32'(sat(m_ev, 16)) : 32'd0);
      chk("taken_cnt", 32'(bus.taken_cnt),
          STATS ? 32'(sat(m_tk, 16)) : 32'd0);
      chk("eval_cnt4", 32'(bus4.eval_cnt),
          STATS ? 32'(sat(m_ev, 4)) : 32'd0);
      chk("taken_cnt4", 32'(bus4.taken_cnt),
          STATS ? 32'(sat(m_tk, 4)) : 32'd0);
   end

   logic [15:0] vimm [7];
   logic [3:0]  vexp [7];
   logic [3:0]  row;
   logic [15:0] svals [5];

   initial begin
      vimm[0] = 16'h0000; vexp[0] = 4'b0011;
      vimm[1] = 16'd3;    vexp[1] = 4'b1110;
      vimm[2] = -16'sd99; vexp[2] = 4'b1000;
      vimm[3] = 16'd1;    vexp[3] = 4'b1110;
      vimm[4] = 16'hFFFF; vexp[4] = 4'b1000;
      vimm[5] = 16'h7FFF; vexp[5] = 4'b1110;
      vimm[6] = 16'h8000; vexp[6] = 4'b1000;
      svals[0] = 16'd3;  svals[1] = 16'hFFFF; svals[2] = 16'd5;
      svals[3] = 16'd0;  svals[4] = 16'd7;

      drive(16'd0, 2'd0, 1'b0, 1'b0);
      #3;
      chk("rst_out_q", 32'(bus.out_q), 32'd0);
      chk("rst_valid", 32'(bus.out_q_valid), 32'd0);
      chk("rst_eval_cnt", 32'(bus.eval_cnt), 32'd0);
      chk("rst_taken_cnt", 32'(bus.taken_cnt), 32'd0);
      #19;
      rst_n = 1'b1;
      cyc();

      for (int i = 0; i < 7; i++) begin
         for (int t = 0; t < 4; t++) begin
            drive(vimm[i], 2'(t), 1'b0, 1'b0);
            #10;
            row = vexp[i];
            chk($sformatf("sweep_%0h_t%0d", vimm[i], t),
                32'(bus.out), 32'(row[t]));
         end
      end

      cyc();
      drive(16'd3, 2'd2, 1'b1, 1'b0);
      cyc();
      drive(16'd3, 2'd2, 1'b0, 1'b0);
      chk("reg_out_q", 32'(bus.out_q), 32'd1);
      chk("reg_valid", 32'(bus.out_q_valid), 32'd1);
      cyc();
      chk("hold_out_q", 32'(bus.out_q), 32'd1);
      chk("hold_valid", 32'(bus.out_q_valid), 32'd0);
      drive(16'd3, 2'd2, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("arst_out_q", 32'(bus.out_q), 32'd0);
      chk("arst_valid", 32'(bus.out_q_valid), 32'd0);
      cyc();
      chk("arst_hold_q", 32'(bus.out_q), 32'd0);
      drive(16'd0, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      cyc();

      for (int i = 0; i < 5; i++) begin
         drive(svals[i], 2'd2, 1'b1, 1'b0);
         cyc();
         chk("b2b_valid", 32'(bus.out_q_valid), 32'd1);
      end
      drive(16'd0, 2'd0, 1'b0, 1'b0);
      chk("stats_eval5", 32'(bus.eval_cnt), STATS ? 32'd5 : 32'd0);
      chk("stats_taken3", 32'(bus.taken_cnt), STATS ? 32'd3 : 32'd0);
      drive(16'd1, 2'd1, 1'b1, 1'b1);
      cyc();
      drive(16'd0, 2'd0, 1'b0, 1'b0);
      chk("clr_eval", 32'(bus.eval_cnt), 32'd0);
      chk("clr_taken", 32'(bus.taken_cnt), 32'd0);
      chk("clr_out_q", 32'(bus.out_q), 32'd1);

      for (int i = 0; i < 20; i++) begin
         drive(16'd1, 2'd3, 1'b1, 1'b0);
         cyc();
      end
      drive(16'd0, 2'd0, 1'b0, 1'b0);
      chk("sat_eval4", 32'(bus4.eval_cnt), STATS ? 32'd15 : 32'd0);
      chk("sat_taken4", 32'(bus4.taken_cnt), STATS ? 32'd15 : 32'd0);
      chk("sat_eval16", 32'(bus.eval_cnt), STATS ? 32'd20 : 32'd0);
      chk("sat_taken16", 32'(bus.taken_cnt), STATS ? 32'd20 : 32'd0);
      cyc();
      cyc();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
